// File: rtl/adsr_sequencer.sv
// Eight-step gate/level sequencer driving an ADSR voice: a tick prescaler paces
// steps from a small writable table, producing gate, wave select and level per step.
module adsr_sequencer #(
  parameter int TICK_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [9:0] wr_data,
  input  logic [2:0] last_step,
  input  logic [7:0] step_ticks,
  input  logic [7:0] gate_len,
  output logic       gate,
  output logic       wave_select,
  output logic [7:0] level,
  output logic [2:0] step_idx,
  output logic       busy,
  output logic       wrap
);

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GATE_ON  = 2'd1,
    GATE_OFF = 2'd2
  } state_t;

  state_t      state_reg;
  logic [15:0] presc_reg;
  logic [7:0]  st_cnt_reg;
  logic        retrig_reg;
  logic [9:0]  step_mem [0:7];

  logic        tick;
  logic [8:0]  st_cnt_inc;
  logic [8:0]  step_len;
  logic        step_end;
  logic        gate_off;
  logic        at_last;
  logic [2:0]  load_idx;
  logic [9:0]  load_entry;
  logic        load_gated;

  // Table has no reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      step_mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    tick       = (state_reg != IDLE) && (presc_reg == TICK_LAST);
    st_cnt_inc = {1'b0, st_cnt_reg} + 9'd1;
    step_len   = (step_ticks == 8'd0) ? 9'd1 : {1'b0, step_ticks};
    step_end   = tick && (st_cnt_inc >= step_len);
    gate_off   = tick && (state_reg == GATE_ON) && (st_cnt_inc == {1'b0, gate_len});
    at_last    = (step_idx >= last_step);
    if ((state_reg == IDLE) || at_last) begin
      load_idx = 3'd0;
    end else begin
      load_idx = step_idx + 3'd1;
    end
    // A write landing on the entry being loaded is forwarded straight into the load.
    load_entry = (wr_en && (wr_addr == load_idx)) ? wr_data : step_mem[load_idx];
    load_gated = load_entry[9] && (gate_len != 8'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      presc_reg   <= '0;
      st_cnt_reg  <= '0;
      retrig_reg  <= 1'b0;
      step_idx    <= '0;
      gate        <= 1'b0;
      wave_select <= 1'b0;
      level       <= '0;
      busy        <= 1'b0;
      wrap        <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (state_reg == IDLE) begin
        presc_reg <= '0;
        if (run) begin
          state_reg   <= load_gated ? GATE_ON : GATE_OFF;
          busy        <= 1'b1;
          step_idx    <= load_idx;
          st_cnt_reg  <= '0;
          wave_select <= load_entry[8];
          level       <= load_entry[7:0];
          gate        <= load_gated;
          retrig_reg  <= 1'b0;
        end
      end else if (!run) begin
        state_reg  <= IDLE;
        busy       <= 1'b0;
        gate       <= 1'b0;
        step_idx   <= '0;
        st_cnt_reg <= '0;
        presc_reg  <= '0;
        retrig_reg <= 1'b0;
      end else begin
        presc_reg <= tick ? '0 : presc_reg + 16'd1;
        if (step_end) begin
          state_reg   <= load_gated ? GATE_ON : GATE_OFF;
          step_idx    <= load_idx;
          st_cnt_reg  <= '0;
          wave_select <= load_entry[8];
          level       <= load_entry[7:0];
          wrap        <= at_last;
          // A still-high gate drops for one cycle so the envelope sees a new trigger.
          gate        <= load_gated && !gate;
          retrig_reg  <= load_gated && gate;
        end else begin
          if (tick) begin
            st_cnt_reg <= st_cnt_reg + 8'd1;
          end
          if (gate_off) begin
            gate      <= 1'b0;
            state_reg <= GATE_OFF;
          end else if (retrig_reg) begin
            gate <= 1'b1;
          end
          retrig_reg <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_adsr_sequencer.sv
// Randomised playback bench for adsr_sequencer (TICK_DIV=4) with an arithmetic
// reference model of step timing, gating and wrap, plus directed corner scenarios.
module tb_adsr_sequencer;

  localparam int TD = 4;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [9:0] wr_data;
  logic [2:0] last_step;
  logic [7:0] step_ticks;
  logic [7:0] gate_len;
  logic       gate;
  logic       wave_select;
  logic [7:0] level;
  logic [2:0] step_idx;
  logic       busy;
  logic       wrap;

  logic       m_valid [8];
  logic       m_wave  [8];
  logic [7:0] m_level [8];

  int n_checks;
  int n_pass;

  adsr_sequencer #(.TICK_DIV(TD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .last_step   (last_step),
    .step_ticks  (step_ticks),
    .gate_len    (gate_len),
    .gate        (gate),
    .wave_select (wave_select),
    .level       (level),
    .step_idx    (step_idx),
    .busy        (busy),
    .wrap        (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [2:0] a, input logic v, input logic w, input logic [7:0] l);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = {v, w, l};
    tick_clk();
    wr_en      = 1'b0;
    m_valid[a] = v;
    m_wave[a]  = w;
    m_level[a] = l;
  endtask

  task automatic stop_run();
    run = 1'b0;
    tick_clk();
    tick_clk();
  endtask

  task automatic test_reset();
    logic [14:0] got;
    #2;
    got = {gate, wave_select, level, step_idx, busy, wrap};
    n_checks++;
    if (got !== 15'd0) $display("FAIL reset_async: got %h expected 0", got);
    else n_pass++;
    tick_clk();
    got = {gate, wave_select, level, step_idx, busy, wrap};
    n_checks++;
    if (got !== 15'd0) $display("FAIL reset_held: got %h expected 0", got);
    else n_pass++;
    #2 rst_n = 1'b1;
    tick_clk();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b expected 0", busy);
    else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_playback();
    logic [14:0] got;
    logic [14:0] exp_v;
    int len, n_t, s, t, idx, prv;
    bit first, g, gp, eg, ew;
    for (int r = 0; r < 8; r++) begin
      for (int a = 0; a < 8; a++) begin
        if (r < 3 && a < 4)
          write_entry(3'(a), !(r == 1 && a == 1), 1'b0, 8'((a + 1) * 10));
        else
          write_entry(3'(a), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      8'($urandom_range(0, 255)));
      end
      if (r < 3) begin
        last_step  = 3'd3;
        step_ticks = 8'd2;
        gate_len   = (r == 2) ? 8'd5 : 8'd1;
      end else begin
        last_step  = 3'($urandom_range(0, 7));
        step_ticks = 8'($urandom_range(0, 3));
        gate_len   = 8'($urandom_range(0, 4));
      end
      run = 1'b1;
      len = (step_ticks == 8'd0) ? 1 : int'(step_ticks);
      for (int n = 0; n < 100; n++) begin
        tick_clk();
        n_t   = n / TD;
        s     = n_t / len;
        t     = n_t % len;
        idx   = s % (int'(last_step) + 1);
        prv   = (idx == 0) ? int'(last_step) : idx - 1;
        first = (n == s * len * TD);
        g     = m_valid[idx] && (gate_len != 8'd0);
        gp    = m_valid[prv] && (gate_len != 8'd0);
        eg    = g && (t < int'(gate_len)) && !(first && s > 0 && gp && int'(gate_len) >= len);
        ew    = first && (s > 0) && (idx == 0);
        exp_v = {eg, m_wave[idx], m_level[idx], 3'(idx), 1'b1, ew};
        got   = {gate, wave_select, level, step_idx, busy, wrap};
        n_checks++;
        if (got !== exp_v)
          $display("FAIL play r%0d n%0d {gate,wave,level,idx,busy,wrap}: got %h expected %h",
                   r, n, got, exp_v);
        else n_pass++;
      end
      $display("playback round %0d last_step=%0d step_ticks=%0d gate_len=%0d",
               r, last_step, step_ticks, gate_len);
      stop_run();
    end
  endtask

  task automatic test_run_drop();
    write_entry(3'd0, 1'b1, 1'b0, 8'd7);
    write_entry(3'd1, 1'b1, 1'b1, 8'd9);
    last_step  = 3'd7;
    step_ticks = 8'd1;
    gate_len   = 8'd1;
    run = 1'b1;
    tick_clk();
    tick_clk();
    tick_clk();
    n_checks++;
    if ({gate, busy} !== 2'b11) $display("FAIL drop_pre {gate,busy}: got %b expected 11", {gate, busy});
    else n_pass++;
    run = 1'b0;
    tick_clk();
    n_checks++;
    if ({gate, busy, step_idx} !== 5'b0) $display("FAIL drop_idle {gate,busy,idx}: got %b expected 00000", {gate, busy, step_idx});
    else n_pass++;
    run = 1'b1;
    tick_clk();
    n_checks++;
    if ({gate, busy, step_idx, level} !== {2'b11, 3'd0, 8'd7})
      $display("FAIL drop_restart: got %h expected %h", {gate, busy, step_idx, level}, {2'b11, 3'd0, 8'd7});
    else n_pass++;
    tick_clk();
    tick_clk();
    tick_clk();
    n_checks++;
    if (step_idx !== 3'd0) $display("FAIL drop_tick_early step_idx: got %0d expected 0", step_idx);
    else n_pass++;
    tick_clk();
    n_checks++;
    if ({step_idx, gate} !== {3'd1, 1'b0}) $display("FAIL drop_first_tick {idx,gate}: got %b expected 0010", {step_idx, gate});
    else n_pass++;
    tick_clk();
    n_checks++;
    if (gate !== 1'b1) $display("FAIL drop_retrigger gate: got %b expected 1", gate);
    else n_pass++;
    $display("test_run_drop done");
    stop_run();
  endtask

  task automatic test_write_through();
    for (int a = 0; a < 8; a++) write_entry(3'(a), 1'b1, 1'b0, 8'(a * 3));
    last_step  = 3'd7;
    step_ticks = 8'd1;
    gate_len   = 8'd1;
    run = 1'b1;
    for (int n = 0; n < 4; n++) tick_clk();
    wr_en   = 1'b1;
    wr_addr = 3'd1;
    wr_data = {1'b1, 1'b1, 8'hA5};
    tick_clk();
    n_checks++;
    if ({step_idx, wave_select, level} !== {3'd1, 1'b1, 8'hA5})
      $display("FAIL bypass {idx,wave,level}: got %h expected %h", {step_idx, wave_select, level}, {3'd1, 1'b1, 8'hA5});
    else n_pass++;
    wr_data = {1'b1, 1'b0, 8'h3C};
    tick_clk();
    wr_en = 1'b0;
    n_checks++;
    if ({wave_select, level} !== {1'b1, 8'hA5})
      $display("FAIL playing_write_hold {wave,level}: got %h expected %h", {wave_select, level}, {1'b1, 8'hA5});
    else n_pass++;
    n_checks++;
    if (gate !== 1'b1) $display("FAIL bypass_gate: got %b expected 1", gate);
    else n_pass++;
    m_valid[1] = 1'b1;
    m_wave[1]  = 1'b0;
    m_level[1] = 8'h3C;
    $display("test_write_through done");
    stop_run();
  endtask

  task automatic test_last_step();
    last_step  = 3'd7;
    step_ticks = 8'd1;
    gate_len   = 8'd1;
    run = 1'b1;
    for (int n = 0; n < 13; n++) tick_clk();
    n_checks++;
    if (step_idx !== 3'd3) $display("FAIL last_step_pre idx: got %0d expected 3", step_idx);
    else n_pass++;
    last_step = 3'd1;
    for (int n = 0; n < 4; n++) tick_clk();
    n_checks++;
    if ({step_idx, wrap} !== {3'd0, 1'b1})
      $display("FAIL last_step_shrink {idx,wrap}: got %b expected 0001", {step_idx, wrap});
    else n_pass++;
    $display("test_last_step done");
    stop_run();
  endtask

  task automatic test_async_reset();
    logic [14:0] got;
    logic [7:0]  exp_l;
    write_entry(3'd0, 1'b1, 1'b0, 8'd11);
    write_entry(3'd1, 1'b1, 1'b1, 8'd22);
    write_entry(3'd2, 1'b1, 1'b0, 8'd33);
    last_step  = 3'd2;
    step_ticks = 8'd1;
    gate_len   = 8'd2;
    run = 1'b1;
    for (int n = 0; n < 7; n++) tick_clk();
    #3 rst_n = 1'b0;
    #1;
    got = {gate, wave_select, level, step_idx, busy, wrap};
    n_checks++;
    if (got !== 15'd0) $display("FAIL async_reset_outputs: got %h expected 0", got);
    else n_pass++;
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int n = 0; n < 9; n++) begin
      tick_clk();
      if (n % 4 == 0) begin
        exp_l = 8'(11 * (n / 4 + 1));
        n_checks++;
        if (level !== exp_l) $display("FAIL retained_level n%0d: got %0d expected %0d", n, level, exp_l);
        else n_pass++;
      end
    end
    $display("test_async_reset done");
    stop_run();
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rst_n      = 1'b0;
    run        = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = 3'd0;
    wr_data    = 10'd0;
    last_step  = 3'd0;
    step_ticks = 8'd1;
    gate_len   = 8'd1;
    test_reset();
    test_playback();
    test_run_drop();
    test_write_through();
    test_last_step();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adsr_sequencer.md
ADSR_SEQUENCER -- requirements
Module: adsr_sequencer

Interface
REQ-001 The module SHALL have parameter TICK_DIV, default 1000, meaning the number of clk cycles per sequencer tick (legal range 2..65535).
REQ-002 The module SHALL have port clk, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-004 The module SHALL have port run, input, 1 bit, a level-sensitive enable for pattern playback.
REQ-005 The module SHALL have ports wr_en (input, 1 bit), wr_addr (input, 3 bits) and wr_data (input, 10 bits), forming the step-table write port; wr_data is {valid, wave_select, level[7:0]}.
REQ-006 The module SHALL have port last_step, input, 3 bits, the index of the final step before wrap.
REQ-007 The module SHALL have port step_ticks, input, 8 bits, the step duration in ticks; the value 0 is treated as 1.
REQ-008 The module SHALL have port gate_len, input, 8 bits, the gate-high duration in ticks; the value 0 means a rest.
REQ-009 The module SHALL have output ports gate (1 bit), wave_select (1 bit) and level (8 bits), registered; they drive the voice trigger, the waveform select and the ADSR sustain/peak level.
REQ-010 The module SHALL have output ports step_idx (3 bits, current step), busy (1 bit, high when not IDLE) and wrap (1 bit, a 1-cycle pulse).

Function
REQ-011 The step table SHALL be 8 entries of 10 bits, written synchronously when wr_en=1, in any state.
REQ-012 The FSM SHALL have three states: IDLE, GATE_ON and GATE_OFF.
REQ-013 The tick prescaler SHALL count 0..TICK_DIV-1 only while busy, and SHALL assert an internal tick on the cycle it equals TICK_DIV-1, then wrap to 0.
REQ-014 The prescaler SHALL be cleared whenever the FSM is in IDLE, so the first tick occurs exactly TICK_DIV cycles after playback starts.
REQ-015 In IDLE with run=1, on the next edge the FSM SHALL load step 0 and clear the 8-bit step timer st_cnt.
REQ-016 When loading step 0 from IDLE, the FSM SHALL enter GATE_ON if the entry's valid=1 and gate_len!=0, and GATE_OFF otherwise.
REQ-017 A step load SHALL register wave_select and level from the entry, set step_idx, and drive gate high exactly when the FSM enters GATE_ON.
REQ-018 In GATE_ON/GATE_OFF, each tick SHALL increment st_cnt.
REQ-019 On a tick in GATE_ON where st_cnt+1 == gate_len, gate SHALL deassert and the FSM SHALL enter GATE_OFF.
REQ-020 On a tick where st_cnt+1 >= max(step_ticks,1), the step SHALL end.
REQ-021 On a step end, the next index SHALL be 0 if step_idx >= last_step and step_idx+1 otherwise, and the next step SHALL be loaded in the same cycle per REQ-016/017.
REQ-022 When gate_len >= step_ticks, step-end takes priority over gate-off: gate SHALL go low for exactly 1 clk cycle between steps when both steps are gated.
REQ-023 This 1-cycle gap SHALL be implemented as the load asserting gate on the following edge, so the ADSR sees a fresh trigger.
REQ-024 wrap SHALL pulse for 1 cycle, coincident with the load, when the step index returns to 0 from last_step; it SHALL NOT pulse on the start from IDLE.
REQ-025 If a write targets the entry being loaded in the same cycle, the load SHALL use the new wr_data (write-through bypass).
REQ-026 A write to the currently playing step SHALL NOT alter the outputs until that step is next loaded.
REQ-027 When run=0 in any active state, on the next edge gate SHALL be forced to 0, the FSM SHALL enter IDLE, and step_idx and st_cnt SHALL clear to 0.
REQ-028 In IDLE, wave_select and level SHALL hold their last values.
REQ-029 Changes to last_step, step_ticks and gate_len SHALL take effect on the next comparison; a last_step below the current step_idx SHALL cause a wrap at the current step's end.

Reset
REQ-030 While rst_n=0, all of the following SHALL be 0: state (IDLE), the prescaler, st_cnt, step_idx, gate, wave_select, level, busy and wrap.
REQ-031 Reset SHALL NOT clear the step-table contents; their content after power-up is undefined until written.
REQ-032 Deassertion of rst_n SHALL take effect on the first clk edge after it, with run sampled from that edge.

Verification (TICK_DIV=4)
REQ-033 Write steps 0..3 as valid with level 10/20/30/40, set last_step=3, step_ticks=2, gate_len=1, raise run: gate SHALL be high 4 cycles and low 4 cycles per step, level SHALL be 10,20,30,40,10, and wrap SHALL pulse once at the return to step 0.
REQ-034 Write step 1 with valid=0: during step 1, gate SHALL stay 0 for all 8 cycles while step_idx=1 and level updates.
REQ-035 Set gate_len=5 and step_ticks=2 with all steps valid: gate SHALL be high 7 cycles, low 1 cycle, then repeat; no step SHALL exceed 8 cycles.
REQ-036 Drop run mid-GATE_ON: gate=0 and busy=0 on the next edge; re-raising run SHALL restart at step 0 with the first tick 4 cycles later.
REQ-037 Write the next step's entry in the exact cycle it is loaded: the output level SHALL equal the newly written value.
REQ-038 Assert rst_n=0 asynchronously mid-step: all outputs SHALL be 0 before the next clk edge, and the table SHALL be retained, replaying the same levels after run.
